wb_byte_bus_bridge: RTL and testbench

//  Wishbone slave that converts 32-bit data-bus accesses into sequential 8-bit byte-bus

---
 rtl/wb_byte_bus_bridge.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_wb_byte_bus_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_byte_bus_bridge
// Purpose  : Wishbone slave that splits each 32-bit data-bus access into
//            sequential 8-bit byte-bus accesses. Byte lanes are serviced MSB
//            lane first (big-endian: sel[3] = bits 31:24 = byte offset 0).
//            The upstream access is acked once, after the last byte.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   wb_clk, wb_rst_n       bus clock, asynchronous active-low reset
//   wbs_*                  upstream 32-bit Wishbone slave port
//                          (cti/bte ignored, rty tied low)
//   wbm_*                  downstream 8-bit Wishbone master port
// Options
//   WB_BYTE_BUS_BRIDGE_TIMEOUT_EN
//       When defined, a TIMEOUT_WIDTH-bit watchdog aborts a byte access that
//       waits in REQ until the counter reaches all-ones (reported as error).
//       When undefined, REQ waits indefinitely for ack/err.
// ============================================================================
module wb_byte_bus_bridge #(
    parameter int WB_ADR_WIDTH  = 32,
    parameter int WB_DAT_WIDTH  = 32,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    // upstream slave port
    input  logic [WB_ADR_WIDTH-1:0] wbs_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] wbs_dat_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic                    wbs_we_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic [2:0]              wbs_cti_i,
    input  logic [1:0]              wbs_bte_i,
    output logic [WB_DAT_WIDTH-1:0] wbs_dat_o,
    output logic                    wbs_ack_o,
    output logic                    wbs_err_o,
    output logic                    wbs_rty_o,
    // downstream byte master port
    output logic [WB_ADR_WIDTH-1:0] wbm_adr_o,
    output logic [7:0]              wbm_dat_o,
    output logic                    wbm_we_o,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    input  logic [7:0]              wbm_dat_i,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    // Elaboration-time parameter sanity checks
    if (WB_DAT_WIDTH != 32) begin : g_dat_width_check
        $error("wb_byte_bus_bridge: WB_DAT_WIDTH must be 32 (4 byte lanes)");
    end
    if (TIMEOUT_WIDTH < 2) begin : g_timeout_width_check
        $error("wb_byte_bus_bridge: TIMEOUT_WIDTH must be at least 2");
    end

    // ------------------------------------------------------------------
    // Lane helpers: offset 0 is the most significant byte
    // ------------------------------------------------------------------
    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] d, input logic [1:0] off,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = d;
        case (off)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    // Lowest pending offset; mask bit (3 - offset) belongs to offset
    function automatic logic [1:0] first_lane(input logic [3:0] mask);
        logic [1:0] off;
        if (mask[3])      off = 2'd0;
        else if (mask[2]) off = 2'd1;
        else if (mask[1]) off = 2'd2;
        else              off = 2'd3;
        return off;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]              state_q,   state_d;
    logic [3:0]              pend_q,    pend_d;     // lanes still to transfer
    logic [WB_DAT_WIDTH-1:0] wdat_q,    wdat_d;     // latched write word
    logic                    fail_q,    fail_d;     // RESP reports error
    logic                    hold_q,    hold_d;     // extra RESP cycle for empty access
    logic [WB_ADR_WIDTH-1:0] wbm_adr_q, wbm_adr_d;
    logic [7:0]              wbm_dat_q, wbm_dat_d;
    logic                    wbm_we_q,  wbm_we_d;
    logic                    wbm_cyc_q, wbm_cyc_d;
    logic                    wbm_stb_q, wbm_stb_d;
    logic [WB_DAT_WIDTH-1:0] wbs_dat_q, wbs_dat_d;
    logic                    wbs_ack_q, wbs_ack_d;
    logic                    wbs_err_q, wbs_err_d;

    logic                    timeout_hit;
    logic [1:0]              cur_lane;
    logic [3:0]              cur_bit;
    logic [3:0]              pend_left;
    logic [1:0]              new_lane;
    logic [1:0]              next_lane;
    logic                    w_unused_bits;

    // The current lane is always the low address bits on the byte bus
    assign cur_lane  = wbm_adr_q[1:0];
    assign cur_bit   = 4'b1000 >> cur_lane;
    assign pend_left = pend_q & ~cur_bit;
    assign new_lane  = first_lane(wbs_sel_i);
    assign next_lane = first_lane(pend_q);

    // Classic-cycle only; word-aligned addressing
    assign w_unused_bits = ^{wbs_cti_i, wbs_bte_i, wbs_adr_i[1:0]};

    // ------------------------------------------------------------------
    // Byte-wait watchdog
    // ------------------------------------------------------------------
`ifdef WB_BYTE_BUS_BRIDGE_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero outside REQ, so every REQ entry starts a fresh count
    always_comb begin
        tmo_cnt_d   = '0;
        timeout_hit = 1'b0;
        if (state_q == c_st_req && !wbm_ack_i && !wbm_err_i) begin
            tmo_cnt_d   = tmo_cnt_q + 1'b1;
            timeout_hit = &tmo_cnt_d;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        wdat_d    = wdat_q;
        fail_d    = fail_q;
        hold_d    = hold_q;
        wbm_adr_d = wbm_adr_q;
        wbm_dat_d = wbm_dat_q;
        wbm_we_d  = wbm_we_q;
        wbm_cyc_d = wbm_cyc_q;
        wbm_stb_d = wbm_stb_q;
        wbs_dat_d = wbs_dat_q;
        wbs_ack_d = 1'b0;
        wbs_err_d = 1'b0;

        case (state_q)
            c_st_idle: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    wdat_d    = wbs_dat_i;
                    wbs_dat_d = '0;
                    fail_d    = 1'b0;
                    pend_d    = wbs_sel_i;
                    if (wbs_sel_i == 4'b0000) begin
                        // No lanes: respond without touching the byte bus,
                        // still taking the two-cycle minimum latency
                        hold_d  = 1'b1;
                        state_d = c_st_resp;
                    end else begin
                        wbm_adr_d = {wbs_adr_i[WB_ADR_WIDTH-1:2], new_lane};
                        wbm_dat_d = lane_byte(wbs_dat_i, new_lane);
                        wbm_we_d  = wbs_we_i;
                        wbm_cyc_d = 1'b1;
                        wbm_stb_d = 1'b1;
                        state_d   = c_st_req;
                    end
                end
            end

            c_st_req: begin
                if (!wbs_cyc_i) begin
                    // Master abandoned the access: silent return to idle
                    pend_d    = '0;
                    wbm_we_d  = 1'b0;
                    wbm_cyc_d = 1'b0;
                    wbm_stb_d = 1'b0;
                    state_d   = c_st_idle;
                end else if (wbm_err_i || timeout_hit) begin
                    // Error takes priority over a simultaneous ack
                    pend_d    = '0;
                    fail_d    = 1'b1;
                    wbm_we_d  = 1'b0;
                    wbm_cyc_d = 1'b0;
                    wbm_stb_d = 1'b0;
                    state_d   = c_st_resp;
                end else if (wbm_ack_i) begin
                    if (!wbm_we_q) begin
                        wbs_dat_d = put_byte(wbs_dat_q, cur_lane, wbm_dat_i);
                    end
                    pend_d = pend_left;
                    if (pend_left != 4'b0000) begin
                        // Strobe gap stops a registered-ack slave double-acking
                        wbm_stb_d = 1'b0;
                        state_d   = c_st_gap;
                    end else begin
                        wbm_we_d  = 1'b0;
                        wbm_cyc_d = 1'b0;
                        wbm_stb_d = 1'b0;
                        state_d   = c_st_resp;
                    end
                end
            end

            c_st_gap: begin
                if (!wbs_cyc_i) begin
                    pend_d    = '0;
                    wbm_we_d  = 1'b0;
                    wbm_cyc_d = 1'b0;
                    wbm_stb_d = 1'b0;
                    state_d   = c_st_idle;
                end else begin
                    wbm_adr_d = {wbm_adr_q[WB_ADR_WIDTH-1:2], next_lane};
                    wbm_dat_d = lane_byte(wdat_q, next_lane);
                    wbm_stb_d = 1'b1;
                    state_d   = c_st_req;
                end
            end

            default: begin // c_st_resp
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    wbs_ack_d = !fail_q;
                    wbs_err_d = fail_q;
                    state_d   = c_st_idle;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= c_st_idle;
            pend_q    <= '0;
            wdat_q    <= '0;
            fail_q    <= 1'b0;
            hold_q    <= 1'b0;
            wbm_adr_q <= '0;
            wbm_dat_q <= '0;
            wbm_we_q  <= 1'b0;
            wbm_cyc_q <= 1'b0;
            wbm_stb_q <= 1'b0;
            wbs_dat_q <= '0;
            wbs_ack_q <= 1'b0;
            wbs_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            wdat_q    <= wdat_d;
            fail_q    <= fail_d;
            hold_q    <= hold_d;
            wbm_adr_q <= wbm_adr_d;
            wbm_dat_q <= wbm_dat_d;
            wbm_we_q  <= wbm_we_d;
            wbm_cyc_q <= wbm_cyc_d;
            wbm_stb_q <= wbm_stb_d;
            wbs_dat_q <= wbs_dat_d;
            wbs_ack_q <= wbs_ack_d;
            wbs_err_q <= wbs_err_d;
        end
    end

    assign wbs_dat_o = wbs_dat_q;
    assign wbs_ack_o = wbs_ack_q;
    assign wbs_err_o = wbs_err_q;
    assign wbs_rty_o = 1'b0;
    assign wbm_adr_o = wbm_adr_q;
    assign wbm_dat_o = wbm_dat_q;
    assign wbm_we_o  = wbm_we_q;
    assign wbm_cyc_o = wbm_cyc_q;
    assign wbm_stb_o = wbm_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_byte_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_byte_bus_bridge
// Purpose  : Directed self-checking bench for wb_byte_bus_bridge with a
//            zero-wait byte-slave model (programmable error/stall byte).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_byte_bus_bridge;

    logic        wb_clk;
    logic        wb_rst_n;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;
    logic [31:0] wbm_adr_o;
    logic [7:0]  wbm_dat_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [7:0]  wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    wb_byte_bus_bridge #(
        .WB_ADR_WIDTH  (32),
        .WB_DAT_WIDTH  (32),
        .TIMEOUT_WIDTH (4)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cti_i (wbs_cti_i),
        .wbs_bte_i (wbs_bte_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_err_o (wbs_err_o),
        .wbs_rty_o (wbs_rty_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Byte-slave model: combinational response while cyc&stb
    // ------------------------------------------------------------------
    logic [7:0]  rd_data [4];
    int          slv_base     = 0;
    int          slv_err_at   = -1;
    int          slv_stall_at = -1;
    logic        slv_late_ack = 1'b0;
    int          slv_k;
    int          byte_cnt     = 0;
    logic [31:0] log_adr [64];
    logic [7:0]  log_dat [64];
    logic        log_we  [64];

    always_comb begin
        slv_k     = byte_cnt - slv_base;
        wbm_ack_i = slv_late_ack;
        wbm_err_i = 1'b0;
        wbm_dat_i = 8'h00;
        if (wbm_cyc_o && wbm_stb_o) begin
            if (slv_k == slv_stall_at) begin
                wbm_ack_i = slv_late_ack;
            end else if (slv_k == slv_err_at) begin
                wbm_err_i = 1'b1;
            end else begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = rd_data[slv_k[1:0]];
            end
        end
    end

    always @(posedge wb_clk) begin
        if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
            log_adr[byte_cnt[5:0]] <= wbm_adr_o;
            log_dat[byte_cnt[5:0]] <= wbm_dat_o;
            log_we[byte_cnt[5:0]]  <= wbm_we_o;
            byte_cnt               <= byte_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge wb_clk);
        @(negedge wb_clk);
    endtask

    task automatic slave_setup(input int err_at, input int stall_at);
        slv_base     = byte_cnt;
        slv_err_at   = err_at;
        slv_stall_at = stall_at;
    endtask

    // One upstream access as a classic master: drop cyc/stb on ack/err.
    // Cycle c = 0 is the cycle right after the edge that accepts the request.
    task automatic run_access(input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic we, input int ncyc,
                              output int ack_cyc, output int n_ack,
                              output int err_cyc, output int n_err,
                              output logic [31:0] stb_tr, output logic [31:0] cyc_tr);
        ack_cyc = -1; n_ack = 0; err_cyc = -1; n_err = 0;
        stb_tr  = '0; cyc_tr = '0;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        tick();
        for (int c = 0; c < ncyc; c++) begin
            stb_tr[c] = wbm_stb_o;
            cyc_tr[c] = wbm_cyc_o;
            if (wbs_ack_o) begin
                n_ack++;
                if (ack_cyc < 0) ack_cyc = c;
            end
            if (wbs_err_o) begin
                n_err++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (wbs_ack_o || wbs_err_o) begin
                wbs_cyc_i = 1'b0;
                wbs_stb_i = 1'b0;
            end
            tick();
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    int          ack_cyc, n_ack, err_cyc, n_err, b0;
    logic [31:0] stb_tr, cyc_tr, ack_tr;

    initial begin
        wb_rst_n  = 1'b0;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = '0; wbs_bte_i = '0;
        rd_data[0] = 8'h11; rd_data[1] = 8'h22; rd_data[2] = 8'h33; rd_data[3] = 8'h44;
        @(negedge wb_clk);
        @(negedge wb_clk);

        // Reset state
        check("reset_outputs",
              {wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_cyc_o, wbm_stb_o, wbm_we_o},
              64'h0);
        check("reset_wbm_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'h0);
        wb_rst_n = 1'b1;
        tick();

        // 1: 4-lane read, zero-wait slave
        slave_setup(-1, -1);
        b0 = byte_cnt;
        run_access(32'h9000_0004, 32'h0, 4'b1111, 1'b0, 12,
                   ack_cyc, n_ack, err_cyc, n_err, stb_tr, cyc_tr);
        check("t1_ack_cycle", ack_cyc, 8);
        check("t1_ack_count", n_ack, 1);
        check("t1_err_count", n_err, 0);
        check("t1_rdata", wbs_dat_o, 32'h1122_3344);
        check("t1_stb_trace", stb_tr, 32'h55);
        check("t1_cyc_trace", cyc_tr, 32'h7F);
        check("t1_bytes", byte_cnt - b0, 4);
        check("t1_adr_seq", {log_adr[b0][7:0], log_adr[b0+1][7:0], log_adr[b0+2][7:0],
                             log_adr[b0+3][7:0]}, 64'h0405_0607);
        check("t1_adr_hi", log_adr[b0 + 3], 32'h9000_0007);

        // 2: sparse write, two lanes
        slave_setup(-1, -1);
        b0 = byte_cnt;
        run_access(32'h9000_0010, 32'hAABB_CCDD, 4'b0101, 1'b1, 10,
                   ack_cyc, n_ack, err_cyc, n_err, stb_tr, cyc_tr);
        check("t2_ack_cycle", ack_cyc, 4);
        check("t2_ack_count", n_ack, 1);
        check("t2_stb_trace", stb_tr, 32'h5);
        check("t2_cyc_trace", cyc_tr, 32'h7);
        check("t2_bytes", byte_cnt - b0, 2);
        check("t2_wr0", {log_we[b0], log_adr[b0], log_dat[b0]}, {1'b1, 32'h9000_0011, 8'hBB});
        check("t2_wr1", {log_we[b0+1], log_adr[b0+1], log_dat[b0+1]}, {1'b1, 32'h9000_0013, 8'hDD});
        check("t2_rdata_cleared", wbs_dat_o, 32'h0);

        // 3: error on second byte
        slave_setup(1, -1);
        b0 = byte_cnt;
        run_access(32'h9000_0020, 32'h0, 4'b1111, 1'b0, 10,
                   ack_cyc, n_ack, err_cyc, n_err, stb_tr, cyc_tr);
        check("t3_err_cycle", err_cyc, 4);
        check("t3_err_count", n_err, 1);
        check("t3_ack_count", n_ack, 0);
        check("t3_bytes", byte_cnt - b0, 2);
        check("t3_stb_trace", stb_tr, 32'h5);
        check("t3_rdata_partial", wbs_dat_o, 32'h1100_0000);

        // 4: master drops cyc while byte 3 stalls; late ack ignored
        slave_setup(-1, 2);
        b0 = byte_cnt;
        wbs_adr_i = 32'h9000_0040; wbs_sel_i = 4'b1111; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        tick();
        repeat (5) tick();
        check("t4_stalled_stb", wbm_stb_o, 1'b1);
        check("t4_stalled_adr", wbm_adr_o, 32'h9000_0042);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
        check("t4_cyc_dropped", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        slv_late_ack = 1'b1;
        n_ack = 0; n_err = 0;
        for (int c = 0; c < 4; c++) begin
            if (wbs_ack_o) n_ack++;
            if (wbs_err_o) n_err++;
            tick();
        end
        slv_late_ack = 1'b0;
        check("t4_no_resp", {n_ack[7:0], n_err[7:0]}, 16'h0);
        check("t4_bytes", byte_cnt - b0, 2);
        check("t4_rdata_partial", wbs_dat_o, 32'h1122_0000);

        // 5a: empty access
        slave_setup(-1, -1);
        b0 = byte_cnt;
        run_access(32'h9000_0050, 32'h0, 4'b0000, 1'b0, 6,
                   ack_cyc, n_ack, err_cyc, n_err, stb_tr, cyc_tr);
        check("t5_empty_ack_cycle", ack_cyc, 2);
        check("t5_empty_ack_count", n_ack, 1);
        check("t5_empty_no_stb", {stb_tr, cyc_tr}, 64'h0);
        check("t5_empty_bytes", byte_cnt - b0, 0);

        // 5b: back-to-back single-lane reads with stb held high
        slave_setup(-1, -1);
        b0 = byte_cnt;
        rd_data[0] = 8'h5A; rd_data[1] = 8'h5A;
        wbs_adr_i = 32'h9000_0030; wbs_sel_i = 4'b0001; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        stb_tr = '0; ack_tr = '0; n_ack = 0;
        tick();
        for (int c = 0; c < 8; c++) begin
            stb_tr[c] = wbm_stb_o;
            ack_tr[c] = wbs_ack_o;
            if (wbs_ack_o) n_ack++;
            if (n_ack == 2) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            tick();
        end
        check("t5_b2b_stb_trace", stb_tr, 32'h09);
        check("t5_b2b_ack_trace", ack_tr, 32'h24);
        check("t5_b2b_bytes", byte_cnt - b0, 2);
        check("t5_b2b_adr", log_adr[b0 + 1], 32'h9000_0033);
        check("t5_b2b_rdata", wbs_dat_o, 32'h0000_005A);
        rd_data[0] = 8'h11; rd_data[1] = 8'h22;

`ifdef WB_BYTE_BUS_BRIDGE_TIMEOUT_EN
        // 6a: watchdog, slave never responds (TIMEOUT_WIDTH = 4)
        slave_setup(-1, 0);
        run_access(32'h9000_0060, 32'h0, 4'b1000, 1'b0, 24,
                   ack_cyc, n_ack, err_cyc, n_err, stb_tr, cyc_tr);
        check("t6_tmo_err_cycle", err_cyc, 16);
        check("t6_tmo_err_count", n_err, 1);
        check("t6_tmo_ack_count", n_ack, 0);
        check("t6_tmo_stb_trace", stb_tr, 32'h7FFF);
        check("t6_tmo_cyc_trace", cyc_tr, 32'h7FFF);
`endif

        // 6b: asynchronous reset in the middle of a stalled write
        slave_setup(-1, 0);
        wbs_adr_i = 32'h9000_00A0; wbs_dat_i = 32'h1234_5678; wbs_sel_i = 4'b1111;
        wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        tick();
        tick();
        check("t6_pre_reset_busy", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_dat_o}, {3'b111, 8'h12});
        #2;
        wb_rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs",
              {wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbs_ack_o, wbs_err_o, wbs_rty_o}, 64'h0);
        check("t6_async_reset_rdata", wbs_dat_o, 32'h0);
        @(negedge wb_clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wb_rst_n = 1'b1;
        tick();

        // Recovery after reset: single MSB lane read
        slave_setup(-1, -1);
        b0 = byte_cnt;
        rd_data[0] = 8'hAB;
        run_access(32'h9000_0020, 32'h0, 4'b1000, 1'b0, 6,
                   ack_cyc, n_ack, err_cyc, n_err, stb_tr, cyc_tr);
        check("t7_recover_ack_cycle", ack_cyc, 2);
        check("t7_recover_rdata", wbs_dat_o, 32'hAB00_0000);
        check("t7_recover_adr", log_adr[b0], 32'h9000_0020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
